// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage behind the ALU. Takes the ALU result as the effective address,
//   runs one data-memory transaction over a req/gnt/rvalid handshake and returns
//   aligned, extended load data for writeback. Misaligned, illegal-size and
//   timed-out accesses are reported through rsp_fault and never hang the core.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   execute-stage handshake; ready only while idle
//   req_store, req_size,  access descriptor: direction, size (00 byte, 01 half,
//   req_unsigned          10 word, 11 illegal), zero/sign extension for loads
//   req_addr, req_wdata   effective address and store data
//   req_rd                load destination register
//   mem_req, mem_we,      memory request: word address, lane-replicated write
//   mem_addr, mem_wdata,  data and byte enables, held stable until mem_gnt
//   mem_be
//   mem_gnt, mem_rvalid,  memory grant, response/write-ack and read data
//   mem_rdata
//   rsp_valid, rsp_rd,    one-cycle completion pulse with destination register,
//   rsp_data, rsp_fault   load result and fault code (00 ok, 01 misaligned,
//                         10 timeout, 11 illegal size)
//   busy                  high whenever a transaction is in flight
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_fault,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_SIZE     = 2'b11;

    // Last counter value before the transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        store_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh16;
        sh   = rdata >> {off, 3'b000};
        sb   = sh[7:0];
        sh16 = sh[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, sh[7:0]}  : 32'(sb);
            2'b01:   return uns ? {16'd0, sh[15:0]} : 32'(sh16);
            default: return sh;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            rd_q       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rd     <= '0;
            rsp_data   <= '0;
            rsp_fault  <= FAULT_OK;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q    <= req_store;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        off_q      <= req_addr[1:0];
                        rd_q       <= req_rd;
                        if (req_size == 2'b11 || is_misaligned(req_size, req_addr[1:0])) begin
                            // Rejected before issue: no memory request at all.
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_rd    <= '0;
                            rsp_data  <= '0;
                            rsp_fault <= (req_size == 2'b11) ? FAULT_SIZE : FAULT_MISALIGN;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_store ? lane_wdata(req_size, req_wdata) : '0;
                            mem_be    <= req_store ? lane_be(req_size, req_addr[1:0]) : 4'b1111;
                        end
                    end
                end
                REQ, RESP: begin
                    cnt <= cnt + 8'd1;
                    // Completion in the last allowed cycle beats the timeout.
                    if ((state == REQ && mem_gnt && mem_rvalid) || (state == RESP && mem_rvalid)) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_OK;
                        rsp_rd    <= store_q ? 5'd0 : rd_q;
                        rsp_data  <= store_q ? 32'd0 : load_extract(mem_rdata, off_q, size_q, unsigned_q);
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= FAULT_TIMEOUT;
                        rsp_rd    <= '0;
                        rsp_data  <= '0;
                    end else if (state == REQ && mem_gnt) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        busy;

    int n_cmp;
    int n_bad;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Reference: what the bus should carry for a store/load.
    function automatic logic [3:0] ref_be(input logic st, input logic [1:0] sz, input logic [1:0] off);
        if (!st) return 4'hF;
        if (sz == 2'b00) return 4'(1 << off);
        if (sz == 2'b01) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic st, input logic [1:0] sz, input logic [31:0] wd);
        if (!st) return 32'd0;
        if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic un, input logic [1:0] off);
        logic [31:0] v;
        logic [31:0] mask;
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        v = (rd >> (8 * off)) & mask;
        if (!un && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    // One complete access: issue, play the memory side with grant delay gd and
    // response delay rvd (cycles after grant), and check every cycle.
    task automatic access(input string tag, input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd,
                          input int gd, input int rvd, input logic [31:0] rdat);
        int  lim;
        bit  bad;
        bit  ok;
        int  doneidx;
        logic [1:0] off;
        off = ad[1:0];
        lim = 0;
        while (!req_ready && lim < 50) begin
            @(negedge clk);
            lim++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_store = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        bad = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
        if (bad) begin
            chk({tag, " flt_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " flt_code"}, 32'(rsp_fault), (sz == 2'b11) ? 32'd3 : 32'd1);
            chk({tag, " flt_rd"}, 32'(rsp_rd), 32'd0);
            chk({tag, " flt_data"}, rsp_data, 32'd0);
            chk({tag, " flt_noreq"}, 32'(mem_req), 32'd0);
        end else begin
            ok      = (gd + rvd <= TO - 1);
            doneidx = ok ? gd + rvd : TO - 1;
            for (int k = 0; k <= doneidx; k++) begin
                chk({tag, " mem_req"}, 32'(mem_req), (k <= gd) ? 32'd1 : 32'd0);
                chk({tag, " early_rsp"}, 32'(rsp_valid), 32'd0);
                chk({tag, " busy"}, 32'(busy), 32'd1);
                if (k <= gd) begin
                    chk({tag, " addr"}, mem_addr, {ad[31:2], 2'b00});
                    chk({tag, " we"}, 32'(mem_we), 32'(st));
                    chk({tag, " be"}, 32'(mem_be), 32'(ref_be(st, sz, off)));
                    chk({tag, " wdata"}, mem_wdata, ref_wdata(st, sz, wd));
                end
                mem_gnt    = (k == gd);
                mem_rvalid = (k == gd + rvd);
                mem_rdata  = (k == gd + rvd) ? rdat : $urandom;
                @(negedge clk);
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " rsp_fault"}, 32'(rsp_fault), ok ? 32'd0 : 32'd2);
            chk({tag, " rsp_rd"}, 32'(rsp_rd), (ok && !st) ? 32'(rd) : 32'd0);
            chk({tag, " rsp_data"}, rsp_data, (ok && !st) ? ref_load(rdat, sz, un, off) : 32'd0);
            chk({tag, " mem_req_off"}, 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        chk({tag, " pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst be", 32'(mem_be), 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        access("ldb_signed", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 0, 1, 32'h80FF_1234);
        access("sth", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 5'd9, 0, 1, 32'h0);
        access("ldw_misalign", 1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0, 5'd3, 0, 1, 32'h0);
        access("illegal_size", 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 5'd3, 0, 1, 32'h0);
        access("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 5'd4, 20, 0, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid rsp", 32'(rsp_valid), 32'd0);
        chk("late_rvalid ready", 32'(req_ready), 32'd1);
        access("gnt_rvalid_same", 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 5'd12, 0, 0, 32'h8001_0000);
        access("last_cycle_wins", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd13, 1, 2, 32'hCAFE_F00D);
        access("rvalid_too_late", 1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0, 5'd14, 1, 3, 32'hCAFE_F00D);

        // Reset while waiting for the response.
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h200; req_rd = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("resp mem_req", 32'(mem_req), 32'd0);
        chk("resp busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst mem_req", 32'(mem_req), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst ready", 32'(req_ready), 32'd1);
        chk("arst rsp", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("arst no_rsp", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst no_rsp", 32'(rsp_valid), 32'd0);
        access("post_rst_load", 1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0, 5'd21, 0, 1, 32'h0000_A500);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            access($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), ad, $urandom,
                   5'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
